// File: rtl/uarc_recv_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_pkg
//  Brief    : Shared types for the UARC receive arbiter (event kinds, FSM
//             states, word-width derivation).
//  Revision : 1.0  initial release
// ============================================================================
package uarc_pkg;

    typedef enum logic [1:0] {
        UARC_EV_SEND   = 2'd0,
        UARC_EV_INCEPT = 2'd1,
        UARC_EV_KILL   = 2'd2
    } uarc_ev_kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } uarc_state_e;

    localparam int C_UARC_NUM_KINDS = 3;

    function automatic int uarc_word_width(input int word_mag);
        return 1 << word_mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uarc_recv_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_recv_arbiter_if
//  Brief    : Receiver-channel and core-event signal bundle for the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface uarc_recv_arbiter_if #(
    parameter int WORD_WIDTH    = 32,
    parameter int TOTAL_BUSES   = 4,
    parameter int BUS_IDX_WIDTH = 2
);
    logic [TOTAL_BUSES-1:0]                 receiver_enable;
    logic [TOTAL_BUSES-1:0]                 receiver_kills;
    logic [TOTAL_BUSES-1:0]                 receiver_incepts;
    logic [TOTAL_BUSES-1:0]                 receiver_sends;
    logic [TOTAL_BUSES-1:0]                 receiver_kill_acks;
    logic [TOTAL_BUSES-1:0]                 receiver_incept_acks;
    logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_permissions;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_addresses;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_permissions;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_addresses;
    logic [TOTAL_BUSES-1:0]                 bus_mask;
    logic                                   event_valid;
    logic                                   event_accept;
    logic [1:0]                             event_kind;
    logic [BUS_IDX_WIDTH-1:0]               event_bus;
    logic [WORD_WIDTH-1:0]                  event_data;
    logic [WORD_WIDTH-1:0]                  event_permission;
    logic [WORD_WIDTH-1:0]                  event_address;

    // Senders and the core drive the master side; the arbiter is the slave.
    modport master (
        output receiver_enable, receiver_kills, receiver_incepts, receiver_sends,
        output receiver_datas, receiver_self_permissions, receiver_self_addresses,
        output receiver_incept_permissions, receiver_incept_addresses,
        output bus_mask, event_accept,
        input  receiver_kill_acks, receiver_incept_acks, receiver_send_acks,
        input  event_valid, event_kind, event_bus,
        input  event_data, event_permission, event_address
    );

    modport slave (
        input  receiver_enable, receiver_kills, receiver_incepts, receiver_sends,
        input  receiver_datas, receiver_self_permissions, receiver_self_addresses,
        input  receiver_incept_permissions, receiver_incept_addresses,
        input  bus_mask, event_accept,
        output receiver_kill_acks, receiver_incept_acks, receiver_send_acks,
        output event_valid, event_kind, event_bus,
        output event_data, event_permission, event_address
    );
endinterface
`default_nettype wire

// File: rtl/uarc_recv_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_rr_picker
//  Brief    : Combinational rotating-priority picker; fixed lowest-index
//             priority unless UARC_RECV_ROUND_ROBIN_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module uarc_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [IDX_W-1:0] o_grant,
    output logic                  o_any
);

    assign o_any = |i_req;

`ifdef UARC_RECV_ROUND_ROBIN_EN
    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(i_ptr) + i) % N;
            if (!found && i_req[idx]) begin
                found   = 1'b1;
                o_grant = IDX_W'(idx);
            end
        end
    end
`else
    logic w_ptr_unused;
    assign w_ptr_unused = ^i_ptr;

    // Scan high to low so the lowest requesting index is written last.
    always_comb begin
        o_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant = IDX_W'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/uarc_recv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_recv_arbiter
//  Brief    : UARC receive front end: kind-prioritised, masked arbitration,
//             valid/accept to the core, 4-phase ack to the sender.
//             Round-robin pick enabled by UARC_RECV_ROUND_ROBIN_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uarc_recv_arbiter
    import uarc_pkg::*;
#(
    parameter int WORD_MAG      = 5,
    parameter int TOTAL_BUSES   = 4,
    parameter int BUS_IDX_WIDTH = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    uarc_recv_arbiter_if.slave bus
);

    localparam int WORD_WIDTH = uarc_word_width(WORD_MAG);

    uarc_state_e              state_q, state_d;
    uarc_ev_kind_e            kind_q, kind_d;
    logic [BUS_IDX_WIDTH-1:0] bus_q, bus_d;
    logic [WORD_WIDTH-1:0]    data_q, data_d;
    logic [WORD_WIDTH-1:0]    perm_q, perm_d;
    logic [WORD_WIDTH-1:0]    addr_q, addr_d;
    logic [BUS_IDX_WIDTH-1:0] w_ptr;

    logic [TOTAL_BUSES-1:0]   w_elig  [C_UARC_NUM_KINDS];
    logic [BUS_IDX_WIDTH-1:0] w_grant [C_UARC_NUM_KINDS];
    logic                     w_any   [C_UARC_NUM_KINDS];
    uarc_ev_kind_e            w_win_kind;
    logic [BUS_IDX_WIDTH-1:0] w_win_bus;
    logic                     w_latched_req;
    logic [BUS_IDX_WIDTH-1:0] w_next_ptr;
    logic [TOTAL_BUSES-1:0]   w_ack_vec;

    assign w_elig[UARC_EV_SEND]   = bus.receiver_sends   & bus.receiver_enable & bus.bus_mask;
    assign w_elig[UARC_EV_INCEPT] = bus.receiver_incepts & bus.receiver_enable & bus.bus_mask;
    assign w_elig[UARC_EV_KILL]   = bus.receiver_kills   & bus.receiver_enable & bus.bus_mask;

    for (genvar k = 0; k < C_UARC_NUM_KINDS; k++) begin : g_kind_picker
        uarc_rr_picker #(
            .N     (TOTAL_BUSES),
            .IDX_W (BUS_IDX_WIDTH)
        ) u_picker (
            .i_req   (w_elig[k]),
            .i_ptr   (w_ptr),
            .o_grant (w_grant[k]),
            .o_any   (w_any[k])
        );
    end

    always_comb begin
        w_win_kind = UARC_EV_SEND;
        if (w_any[UARC_EV_KILL]) begin
            w_win_kind = UARC_EV_KILL;
        end else if (w_any[UARC_EV_INCEPT]) begin
            w_win_kind = UARC_EV_INCEPT;
        end
    end

    assign w_win_bus  = w_grant[w_win_kind];
    assign w_next_ptr = (bus_q == BUS_IDX_WIDTH'(TOTAL_BUSES - 1)) ? '0 : bus_q + 1'b1;

    // Withdrawal and ack release look at the raw request, ignoring mask/enable.
    always_comb begin
        w_latched_req = 1'b0;
        case (kind_q)
            UARC_EV_KILL:   w_latched_req = bus.receiver_kills[bus_q];
            UARC_EV_INCEPT: w_latched_req = bus.receiver_incepts[bus_q];
            default:        w_latched_req = bus.receiver_sends[bus_q];
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        bus_d   = bus_q;
        data_d  = data_q;
        perm_d  = perm_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (w_any[UARC_EV_KILL] || w_any[UARC_EV_INCEPT] || w_any[UARC_EV_SEND]) begin
                    state_d = PRESENT;
                    kind_d  = w_win_kind;
                    bus_d   = w_win_bus;
                    data_d  = (w_win_kind == UARC_EV_KILL) ? '0 : bus.receiver_datas[w_win_bus];
                    if (w_win_kind == UARC_EV_INCEPT) begin
                        perm_d = bus.receiver_incept_permissions[w_win_bus];
                        addr_d = bus.receiver_incept_addresses[w_win_bus];
                    end else begin
                        perm_d = bus.receiver_self_permissions[w_win_bus];
                        addr_d = bus.receiver_self_addresses[w_win_bus];
                    end
                end
            end
            PRESENT: begin
                if (bus.event_accept) begin
                    state_d = ACK;
                end else if (!w_latched_req) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!w_latched_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            kind_q  <= UARC_EV_SEND;
            bus_q   <= '0;
            data_q  <= '0;
            perm_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            bus_q   <= bus_d;
            data_q  <= data_d;
            perm_q  <= perm_d;
            addr_q  <= addr_d;
        end
    end

`ifdef UARC_RECV_ROUND_ROBIN_EN
    logic [BUS_IDX_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == PRESENT && bus.event_accept) begin
            ptr_d = w_next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_ptr = ptr_q;
`else
    logic w_next_ptr_unused;
    assign w_next_ptr_unused = ^w_next_ptr;
    assign w_ptr             = '0;
`endif

    // Acks are decoded from registered state, so reset drops them on its edge.
    assign w_ack_vec = (state_q == ACK) ? (TOTAL_BUSES'(1) << bus_q) : '0;

    assign bus.receiver_kill_acks   = (kind_q == UARC_EV_KILL)   ? w_ack_vec : '0;
    assign bus.receiver_incept_acks = (kind_q == UARC_EV_INCEPT) ? w_ack_vec : '0;
    assign bus.receiver_send_acks   = (kind_q == UARC_EV_SEND)   ? w_ack_vec : '0;

    assign bus.event_valid      = (state_q == PRESENT);
    assign bus.event_kind       = kind_q;
    assign bus.event_bus        = bus_q;
    assign bus.event_data       = data_q;
    assign bus.event_permission = perm_q;
    assign bus.event_address    = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_uarc_recv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uarc_recv_arbiter
//  Brief    : Scoreboard bench for uarc_recv_arbiter (directed vectors).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uarc_recv_arbiter;

    localparam int C_NB  = 4;
    localparam int C_WW  = 32;
    localparam int C_IW  = 2;
    localparam int C_SEND   = 0;
    localparam int C_INCEPT = 1;
    localparam int C_KILL   = 2;

    typedef struct {
        int          kind;
        int          bus;
        logic [31:0] data;
        logic [31:0] perm;
        logic [31:0] addr;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic prev_valid;

    uarc_recv_arbiter_if #(.WORD_WIDTH(C_WW), .TOTAL_BUSES(C_NB), .BUS_IDX_WIDTH(C_IW)) bus_if ();

    uarc_recv_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(C_NB), .BUS_IDX_WIDTH(C_IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int field, input int b);
        return 32'h1000_0000 * (field + 1) + 32'h11 * b;
    endfunction

    // Expected presentation built from the payload pattern and kind mapping.
    function automatic exp_t mk(input int kind, input int b);
        exp_t e;
        e.kind = kind;
        e.bus  = b;
        e.data = (kind == C_KILL) ? 32'h0 : pat(0, b);
        e.perm = (kind == C_INCEPT) ? pat(3, b) : pat(1, b);
        e.addr = (kind == C_INCEPT) ? pat(4, b) : pat(2, b);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus_if.event_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual kind=%0d bus=%0d required none",
                         bus_if.event_kind, bus_if.event_bus);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus_if.event_kind !== 2'(e.kind) || bus_if.event_bus !== C_IW'(e.bus) ||
                    bus_if.event_data !== e.data || bus_if.event_permission !== e.perm ||
                    bus_if.event_address !== e.addr) begin
                    failures++;
                    $display("FAIL event actual k=%0d b=%0d d=%h p=%h a=%h required k=%0d b=%0d d=%h p=%h a=%h",
                             bus_if.event_kind, bus_if.event_bus, bus_if.event_data,
                             bus_if.event_permission, bus_if.event_address,
                             e.kind, e.bus, e.data, e.perm, e.addr);
                end
            end
        end
        prev_valid <= reset & bus_if.event_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus_if.receiver_kills   = '0;
        bus_if.receiver_incepts = '0;
        bus_if.receiver_sends   = '0;
        bus_if.event_accept     = 1'b0;
        bus_if.bus_mask         = '1;
        bus_if.receiver_enable  = '1;
        for (int b = 0; b < C_NB; b++) begin
            bus_if.receiver_datas[b]              = pat(0, b);
            bus_if.receiver_self_permissions[b]   = pat(1, b);
            bus_if.receiver_self_addresses[b]     = pat(2, b);
            bus_if.receiver_incept_permissions[b] = pat(3, b);
            bus_if.receiver_incept_addresses[b]   = pat(4, b);
        end
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (bus_if.event_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus_if.event_valid !== 1'b1) check({name, "_timeout"}, 32'(bus_if.event_valid), 32'h1);
    endtask

    function automatic logic [3:0] acks_of(input int kind);
        if (kind == C_KILL)   return bus_if.receiver_kill_acks;
        if (kind == C_INCEPT) return bus_if.receiver_incept_acks;
        return bus_if.receiver_send_acks;
    endfunction

    task automatic set_req(input int kind, input int b, input logic v);
        if (kind == C_KILL)        bus_if.receiver_kills[b]   = v;
        else if (kind == C_INCEPT) bus_if.receiver_incepts[b] = v;
        else                       bus_if.receiver_sends[b]   = v;
    endtask

    // Accept the presented event, check the ack, then complete the 4-phase release.
    task automatic serve(input string name, input int kind, input int b, input bit rerise);
        logic [3:0] onehot;
        onehot = 4'b0001 << b;
        wait_valid(name);
        bus_if.event_accept = 1'b1;
        tick();
        bus_if.event_accept = 1'b0;
        check({name, "_ack"}, 32'(acks_of(kind)), 32'(onehot));
        check({name, "_ack_others"}, 32'(acks_of((kind + 1) % 3) | acks_of((kind + 2) % 3)), 32'h0);
        check({name, "_valid_in_ack"}, 32'(bus_if.event_valid), 32'h0);
        set_req(kind, b, 1'b0);
        tick();
        check({name, "_ack_release"}, 32'(acks_of(kind)), 32'h0);
        if (rerise) set_req(kind, b, 1'b1);
    endtask

    initial begin
        int order[$];
        exp_t e;
        checks     = 0;
        failures   = 0;
        prev_valid = 1'b0;

        // Reset held with a pending send
        clear_reqs();
        reset = 1'b0;
        bus_if.receiver_sends = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid", 32'(bus_if.event_valid), 32'h0);
            check("rst_acks", 32'({bus_if.receiver_kill_acks, bus_if.receiver_incept_acks,
                                   bus_if.receiver_send_acks}), 32'h0);
            check("rst_bus", 32'(bus_if.event_bus), 32'h0);
        end
        exp_q.push_back(mk(C_SEND, 2));
        reset = 1'b1;
        tick();
        check("rst_latency_valid", 32'(bus_if.event_valid), 32'h1);
        check("rst_latency_bus", 32'(bus_if.event_bus), 32'h2);
        serve("rst_send", C_SEND, 2, 1'b0);

        // Kill beats send
        do_reset();
        exp_q.push_back(mk(C_KILL, 3));
        exp_q.push_back(mk(C_SEND, 0));
        bus_if.receiver_sends = 4'b0001;
        bus_if.receiver_kills = 4'b1000;
        wait_valid("prio");
        bus_if.event_accept = 1'b1;
        tick();
        bus_if.event_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("prio_kill_ack", 32'(bus_if.receiver_kill_acks), 32'h8);
            check("prio_send_ack_low", 32'(bus_if.receiver_send_acks), 32'h0);
            tick();
        end
        bus_if.receiver_kills = 4'b0000;
        tick();
        check("prio_kill_release", 32'(bus_if.receiver_kill_acks), 32'h0);
        serve("prio_send", C_SEND, 0, 1'b0);

        // Fairness with all sends held (re-raised after each ack)
        do_reset();
`ifdef UARC_RECV_ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0};
`endif
        foreach (order[i]) exp_q.push_back(mk(C_SEND, order[i]));
        bus_if.receiver_sends = 4'b1111;
        foreach (order[i]) serve("fair", C_SEND, order[i], (i != order.size() - 1));
        bus_if.receiver_sends = 4'b0000;
        repeat (3) tick();

        // Masking and receiver_enable
        do_reset();
        exp_q.push_back(mk(C_SEND, 1));
        bus_if.bus_mask       = 4'b1011;
        bus_if.receiver_sends = 4'b0110;
        serve("mask", C_SEND, 1, 1'b0);
        repeat (5) begin
            tick();
            check("mask_ignored", 32'(bus_if.event_valid), 32'h0);
        end
        bus_if.receiver_sends  = 4'b0000;
        bus_if.bus_mask        = 4'b1111;
        bus_if.receiver_enable = 4'b1101;
        bus_if.receiver_sends  = 4'b0010;
        repeat (5) begin
            tick();
            check("enable_off", 32'(bus_if.event_valid), 32'h0);
        end

        // Withdrawal before accept; pointer must stay put
        do_reset();
        exp_q.push_back(mk(C_INCEPT, 1));
        bus_if.receiver_incepts = 4'b0010;
        wait_valid("wdraw");
        tick();
        bus_if.receiver_incepts = 4'b0000;
        tick();
        check("wdraw_valid", 32'(bus_if.event_valid), 32'h0);
        check("wdraw_ack", 32'(bus_if.receiver_incept_acks), 32'h0);
        exp_q.push_back(mk(C_SEND, 1));
        bus_if.receiver_sends = 4'b0110;
        serve("wdraw_ptr", C_SEND, 1, 1'b0);
        bus_if.receiver_sends = 4'b0000;
        repeat (3) tick();

        // Payload latched and stable while inputs change
        do_reset();
        bus_if.receiver_datas[1]          = 32'hDEAD_BEEF;
        bus_if.receiver_self_addresses[1] = 32'h0000_0040;
        e      = mk(C_SEND, 1);
        e.data = 32'hDEAD_BEEF;
        e.addr = 32'h0000_0040;
        exp_q.push_back(e);
        bus_if.receiver_sends = 4'b0010;
        wait_valid("payload");
        bus_if.receiver_datas[1]          = 32'h1234_5678;
        bus_if.receiver_self_addresses[1] = 32'h0000_0099;
        bus_if.receiver_kills             = 4'b0001;
        repeat (3) begin
            tick();
            check("payload_data", bus_if.event_data, 32'hDEAD_BEEF);
            check("payload_addr", bus_if.event_address, 32'h0000_0040);
            check("payload_kind", 32'(bus_if.event_kind), 32'h0);
        end
        bus_if.receiver_kills = 4'b0000;
        serve("payload", C_SEND, 1, 1'b0);
        repeat (3) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
